// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter for the ALU shift path.
// Loads a 2*DATA_WIDTH working register and then shifts it by at most
// MAX_STEP bits per cycle, presenting the wide result with a valid/ready
// handshake. Optional macro SHIFT_SEQ_OPS_COUNT_EN adds a completed-operation
// counter on ops_done; without it ops_done is tied to zero.
module shift_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STEP   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [1:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] output1,
  output logic [31:0]             ops_done
);

  localparam int AW = $clog2(DATA_WIDTH);
  localparam int CW = AW + 1;
  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] MAX_STEP_C = CW'(MAX_STEP);
  localparam logic [CW-1:0] DW_C       = CW'(DATA_WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic [AW-1:0]     rem_q, rem_d;
  logic [1:0]        op_q, op_d;
  logic [WW-1:0]     res_q, res_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [CW-1:0]     rem_ext_s;
  logic [CW-1:0]     step_s;
  logic [AW-1:0]     rem_after_s;
  logic              unused_b_s;

  // Working-register image at accept time: SRA sign-extends, all others zero-extend.
  function automatic logic [WW-1:0] load_value(input logic [DATA_WIDTH-1:0] val,
                                               input logic [1:0] kind);
    logic [WW-1:0] res;
    case (kind)
      OP_SRA:  res = {{DATA_WIDTH{val[DATA_WIDTH-1]}}, val};
      default: res = {{DATA_WIDTH{1'b0}}, val};
    endcase
    return res;
  endfunction

  // One shift step of amt bits; ROL rotates only the low half, upper half stays zero.
  function automatic logic [WW-1:0] shift_step(input logic [WW-1:0] w,
                                               input logic [1:0]    kind,
                                               input logic [CW-1:0] amt);
    logic [DATA_WIDTH-1:0] lo;
    logic [WW-1:0]         res;
    lo = w[DATA_WIDTH-1:0];
    case (kind)
      OP_SLL:  res = w << amt;
      OP_SRL:  res = w >> amt;
      OP_SRA:  res = $signed(w) >>> amt;
      OP_ROL:  res = {{DATA_WIDTH{1'b0}}, (lo << amt) | (lo >> (DW_C - amt))};
      default: res = w;
    endcase
    return res;
  endfunction

  // Only the low log2(DATA_WIDTH) bits of the amount are meaningful.
  assign unused_b_s = ^b[DATA_WIDTH-1:AW];

  // Per-cycle step is min(remaining, MAX_STEP); step never exceeds remaining so it fits AW bits.
  always_comb begin
    rem_ext_s   = {1'b0, rem_q};
    step_s      = (rem_ext_s > MAX_STEP_C) ? MAX_STEP_C : rem_ext_s;
    rem_after_s = rem_q - step_s[AW-1:0];
  end

  // State register plus datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      w_q         <= {WW{1'b0}};
      rem_q       <= {AW{1'b0}};
      op_q        <= 2'b00;
      res_q       <= {WW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: zero amount skips SHIFT, DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = (b[AW-1:0] == {AW{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_after_s == {AW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; result is captured only on entry to DONE so it
  // stays stable under backpressure and holds its last value afterwards.
  always_comb begin
    w_d   = w_q;
    rem_d = rem_q;
    op_d  = op_q;
    res_d = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          w_d   = load_value(a, op);
          rem_d = b[AW-1:0];
          op_d  = op;
        end else begin
          w_d   = w_q;
          rem_d = rem_q;
          op_d  = op_q;
        end
      end
      ST_SHIFT: begin
        w_d   = shift_step(w_q, op_q, step_s);
        rem_d = rem_after_s;
      end
      ST_DONE: begin
        w_d = w_q;
      end
      default: begin
        w_d = w_q;
      end
    endcase
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_d = w_d;
    end else begin
      res_d = res_q;
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign output1   = res_q;

`ifdef SHIFT_SEQ_OPS_COUNT_EN
  logic [31:0] ops_cnt_q;

  // Count every consumed result; wraps naturally at 32 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      ops_cnt_q <= 32'd0;
    end else if (out_valid_q && out_ready) begin
      ops_cnt_q <= ops_cnt_q + 32'd1;
    end else begin
      ops_cnt_q <= ops_cnt_q;
    end
  end

  assign ops_done = ops_cnt_q;
`else
  assign ops_done = 32'd0;
`endif

endmodule
